systolic_ctrl: RTL and testbench

SYSTOLIC_CTRL -- requirements
Module: systolic_ctrl

---
 rtl/mac_pkg.sv | 23 ++
 rtl/systolic_ctrl_feed_skew.sv | 32 +++
 rtl/systolic_ctrl.sv | 142 ++++++++++++++
 tb/tb_systolic_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared constants and types for the systolic MAC-array controller:
// FP8 operand format, array-size default and the controller state encoding.
package mac_pkg;

    localparam int DIM_DEFAULT = 3;

    localparam int FP8_W      = 8;
    localparam int FP8_EXP_W  = 3;
    localparam int FP8_FRAC_W = 4;
    localparam int FP8_BIAS   = 3;

    localparam logic [FP8_W-1:0] FP8_ONE  = 8'h30;
    localparam logic [FP8_W-1:0] FP8_ZERO = 8'h00;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/systolic_ctrl_feed_skew.sv
// Diagonal skew generator: for step t, lane n carries element index t-n of its
// row (A lanes) or column (B lanes) when that index falls inside the matrix.
module feed_skew
    import mac_pkg::*;
#(
    parameter int DIM       = DIM_DEFAULT,
    parameter int AW        = 4,
    parameter int SW        = $clog2(2*DIM),
    parameter bit COL_MAJOR = 1'b0
) (
    input  logic [SW-1:0]     t,
    output logic [DIM*AW-1:0] addr,
    output logic [DIM-1:0]    vld
);

    int k;

    // COL_MAJOR lanes walk down a column (B[k][lane]); otherwise along a row (A[lane][k]).
    always_comb begin
        addr = '0;
        vld  = '0;
        k    = 0;
        for (int lane = 0; lane < DIM; lane++) begin
            k = int'(t) - lane;
            if (k >= 0 && k < DIM) begin
                vld[lane] = 1'b1;
                addr[lane*AW +: AW] = COL_MAJOR ? AW'(k*DIM + lane) : AW'(lane*DIM + k);
            end
        end
    end

endmodule

// File: rtl/systolic_ctrl.sv
// Controller for a DIM x DIM systolic MAC grid: holds the A/B operand buffers and
// sequences clear, skewed operand streaming, pipeline drain and a done pulse.
module systolic_ctrl
    import mac_pkg::*;
#(
    parameter int DIM = DIM_DEFAULT,
    parameter int AW  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               wr_sel,
    input  logic [AW-1:0]      wr_addr,
    input  logic [7:0]         wr_data,
    input  logic               start,
    output logic [8*DIM-1:0]   a_feed,
    output logic [8*DIM-1:0]   b_feed,
    output logic [2*DIM-1:0]   feed_vld,
    output logic               mac_clr,
    output logic               busy,
    output logic               done
);

    localparam int NELEM = DIM*DIM;
    localparam int SW    = $clog2(2*DIM);
    localparam logic [SW-1:0] LAST_T     = SW'(2*DIM-2);
    localparam logic [SW-1:0] LAST_DRAIN = SW'(DIM-1);

    state_t            state;
    logic [SW-1:0]     step;
    logic [SW-1:0]     feed_t;
    logic [FP8_W-1:0]  abuf [NELEM];
    logic [FP8_W-1:0]  bbuf [NELEM];
    logic [DIM*AW-1:0] a_addr;
    logic [DIM*AW-1:0] b_addr;
    logic [DIM-1:0]    a_vld;
    logic [DIM-1:0]    b_vld;
    logic [8*DIM-1:0]  a_next;
    logic [8*DIM-1:0]  b_next;

    // Operand storage deliberately has no reset so matrices survive rst and reruns.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && wr_en && int'(wr_addr) < NELEM) begin
            if (wr_sel)
                bbuf[wr_addr] <= wr_data;
            else
                abuf[wr_addr] <= wr_data;
        end
    end

    // Feeds are registered, so the skew is evaluated for the step about to be entered.
    assign feed_t = (state == ST_STREAM) ? step + 1'b1 : '0;

    feed_skew #(.DIM(DIM), .AW(AW), .SW(SW), .COL_MAJOR(1'b0)) u_skew_a (
        .t    (feed_t),
        .addr (a_addr),
        .vld  (a_vld)
    );

    feed_skew #(.DIM(DIM), .AW(AW), .SW(SW), .COL_MAJOR(1'b1)) u_skew_b (
        .t    (feed_t),
        .addr (b_addr),
        .vld  (b_vld)
    );

    always_comb begin
        a_next = '0;
        b_next = '0;
        for (int lane = 0; lane < DIM; lane++) begin
            if (a_vld[lane])
                a_next[8*lane +: 8] = abuf[a_addr[lane*AW +: AW]];
            if (b_vld[lane])
                b_next[8*lane +: 8] = bbuf[b_addr[lane*AW +: AW]];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            step     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mac_clr  <= 1'b0;
            feed_vld <= '0;
            a_feed   <= '0;
            b_feed   <= '0;
        end else begin
            done     <= 1'b0;
            mac_clr  <= 1'b0;
            feed_vld <= '0;
            a_feed   <= '0;
            b_feed   <= '0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_CLEAR;
                        step    <= '0;
                        busy    <= 1'b1;
                        mac_clr <= 1'b1;
                    end
                end
                ST_CLEAR: begin
                    state    <= ST_STREAM;
                    step     <= '0;
                    a_feed   <= a_next;
                    b_feed   <= b_next;
                    feed_vld <= {b_vld, a_vld};
                end
                ST_STREAM: begin
                    if (step == LAST_T) begin
                        state <= ST_DRAIN;
                        step  <= '0;
                    end else begin
                        step     <= step + 1'b1;
                        a_feed   <= a_next;
                        b_feed   <= b_next;
                        feed_vld <= {b_vld, a_vld};
                    end
                end
                ST_DRAIN: begin
                    if (step == LAST_DRAIN) begin
                        state <= ST_DONE;
                        step  <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        step <= step + 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    step  <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: operand buffers are mirrored in the bench and
// every cycle of a run is compared against the expected clear/skew/drain/done timeline.
module tb_systolic_ctrl;

    localparam int DIM     = 3;
    localparam int AW      = 4;
    localparam int NELEM   = DIM*DIM;
    localparam int RUN_LEN = 3*DIM + 1;

    logic             clk;
    logic             rst;
    logic             wr_en;
    logic             wr_sel;
    logic [AW-1:0]    wr_addr;
    logic [7:0]       wr_data;
    logic             start;
    logic [8*DIM-1:0] a_feed;
    logic [8*DIM-1:0] b_feed;
    logic [2*DIM-1:0] feed_vld;
    logic             mac_clr;
    logic             busy;
    logic             done;

    logic [7:0] refA [NELEM];
    logic [7:0] refB [NELEM];

    int checks = 0;
    int errors = 0;

    systolic_ctrl #(.DIM(DIM), .AW(AW)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_sel   (wr_sel),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .a_feed   (a_feed),
        .b_feed   (b_feed),
        .feed_vld (feed_vld),
        .mac_clr  (mac_clr),
        .busy     (busy),
        .done     (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Lane n at step t carries A[n][t-n] (row lanes) or B[t-n][n] (column lanes).
    function automatic logic [31:0] expFeed(input bit isB, input int t);
        logic [31:0] r;
        r = '0;
        for (int lane = 0; lane < DIM; lane++) begin
            int k;
            k = t - lane;
            if (k >= 0 && k < DIM)
                r[8*lane +: 8] = isB ? refB[k*DIM + lane] : refA[lane*DIM + k];
        end
        return r;
    endfunction

    function automatic logic [31:0] expVld(input int t);
        logic [31:0] r;
        r = '0;
        for (int lane = 0; lane < DIM; lane++) begin
            if (t - lane >= 0 && t - lane < DIM) begin
                r[lane]       = 1'b1;
                r[DIM + lane] = 1'b1;
            end
        end
        return r;
    endfunction

    // Cycle c counts from the start cycle (c=0): c=1 clear, c=2..2*DIM stream, then drain, then done.
    task automatic checkCycle(input int c);
        int t;
        bit streaming;
        t = c - 2;
        streaming = (c >= 2) && (c <= 2*DIM);
        checkOutput($sformatf("c%0d_busy", c), 32'(busy), (c >= 1 && c <= 3*DIM) ? 32'd1 : 32'd0);
        checkOutput($sformatf("c%0d_done", c), 32'(done), (c == RUN_LEN) ? 32'd1 : 32'd0);
        checkOutput($sformatf("c%0d_mac_clr", c), 32'(mac_clr), (c == 1) ? 32'd1 : 32'd0);
        checkOutput($sformatf("c%0d_feed_vld", c), 32'(feed_vld), streaming ? expVld(t) : 32'd0);
        checkOutput($sformatf("c%0d_a_feed", c), 32'(a_feed), streaming ? expFeed(1'b0, t) : 32'd0);
        checkOutput($sformatf("c%0d_b_feed", c), 32'(b_feed), streaming ? expFeed(1'b1, t) : 32'd0);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_done"}, 32'(done), 32'd0);
        checkOutput({tag, "_mac_clr"}, 32'(mac_clr), 32'd0);
        checkOutput({tag, "_feed_vld"}, 32'(feed_vld), 32'd0);
        checkOutput({tag, "_a_feed"}, 32'(a_feed), 32'd0);
        checkOutput({tag, "_b_feed"}, 32'(b_feed), 32'd0);
    endtask

    task automatic writeElem(input logic sel, input logic [AW-1:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        if (int'(addr) < NELEM) begin
            if (sel)
                refB[addr] = data;
            else
                refA[addr] = data;
        end
    endtask

    task automatic loadRandom();
        for (int i = 0; i < NELEM; i++) begin
            writeElem(1'b0, AW'(i), 8'($urandom));
            writeElem(1'b1, AW'(i), 8'($urandom));
        end
    endtask

    // One full run; optional stray start or A-buffer write at cycle startAt/wrAt, or a write
    // issued together with start (wrAtStart). Caller is 1 time unit past an edge, in IDLE.
    task automatic applyStimulus(input int startAt, input int wrAt, input bit wrAtStart,
                                 input logic [AW-1:0] wAddr, input logic [7:0] wData);
        start = 1'b1;
        if (wrAtStart) begin
            wr_en   = 1'b1;
            wr_sel  = 1'b0;
            wr_addr = wAddr;
            wr_data = wData;
            if (int'(wAddr) < NELEM)
                refA[wAddr] = wData;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        wr_en = 1'b0;
        for (int c = 1; c <= RUN_LEN; c++) begin
            checkCycle(c);
            if (c == startAt)
                start = 1'b1;
            if (c == wrAt) begin
                wr_en   = 1'b1;
                wr_sel  = 1'b0;
                wr_addr = wAddr;
                wr_data = wData;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            wr_en = 1'b0;
        end
        checkOutput("post_run_busy", 32'(busy), 32'd0);
        checkOutput("post_run_done", 32'(done), 32'd0);
    endtask

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_sel  = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start   = 1'b0;
        #1;
        checkResetState("por");
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkResetState("after_release");

        $display("[TB] identity run");
        for (int i = 0; i < NELEM; i++) begin
            writeElem(1'b0, AW'(i), (i / DIM == i % DIM) ? 8'h30 : 8'h00);
            writeElem(1'b1, AW'(i), (i / DIM == i % DIM) ? 8'h30 : 8'h00);
        end
        applyStimulus(-1, -1, 1'b0, '0, 8'h00);

        $display("[TB] constant A run");
        for (int i = 0; i < NELEM; i++) begin
            writeElem(1'b0, AW'(i), 8'h40);
            writeElem(1'b1, AW'(i), 8'($urandom));
        end
        applyStimulus(-1, -1, 1'b0, '0, 8'h00);

        $display("[TB] start pulsed mid-stream");
        loadRandom();
        applyStimulus(4, -1, 1'b0, '0, 8'h00);

        $display("[TB] write mid-stream, then rerun");
        applyStimulus(-1, 4, 1'b0, 4'd4, 8'h55);
        applyStimulus(-1, -1, 1'b0, '0, 8'h00);

        $display("[TB] write with start");
        applyStimulus(-1, -1, 1'b1, 4'd0, 8'h38);

        $display("[TB] out-of-range writes");
        writeElem(1'b0, 4'd9, 8'hAA);
        writeElem(1'b1, 4'd15, 8'hBB);
        applyStimulus(-1, -1, 1'b0, '0, 8'h00);

        $display("[TB] reset mid-stream");
        loadRandom();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checkCycle(c);
            if (c < 4) begin
                @(posedge clk);
                #1;
            end
        end
        #2;
        rst = 1'b1;
        #1;
        checkResetState("async_rst");
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            checkOutput($sformatf("aborted_busy_%0d", c), 32'(busy), 32'd0);
            checkOutput($sformatf("aborted_done_%0d", c), 32'(done), 32'd0);
            @(posedge clk);
            #1;
        end
        applyStimulus(-1, -1, 1'b0, '0, 8'h00);

        $display("[TB] random runs");
        for (int r = 0; r < 3; r++) begin
            loadRandom();
            applyStimulus(-1, -1, 1'b0, '0, 8'h00);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
